// File: rtl/plic_ctx_arb_pkg.sv
// Shared types and defaults for the PLIC context arbiter.
//   state_e : arbiter FSM states (IDLE / ISSUE / RESP)
//   op_e    : latched transaction kind (claim, complete, timeout-forced complete)
//   ctx_w() : index width for a given context count (minimum 1 bit)
package plic_ctx_arb_pkg;

    localparam int PLIC_CTX_NUM   = 4;
    localparam int PLIC_IRQ_NUM   = 32;
    localparam int PLIC_IRQ_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_CLAM = 2'd0,
        OP_COMP = 2'd1,
        OP_TMO  = 2'd2
    } op_e;

    function automatic int ctx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plic_ctx_arb_if.sv
// Bundle between the per-context front-ends / plic_core and the arbiter.
//   master : front-ends and core (drive requests, complete IDs, core_id_i)
//   slave  : the arbiter (drives acks, responses, core strobes, timeout pulses)
// Handshake: a context holds ctx_clam_req_i / ctx_comp_req_i (and its ctx_comp_id_i
// slice) high and stable until it sees its one-cycle ctx_ack_o bit; the response
// fields are valid only in that ack cycle. dbg_state exposes the arbiter FSM.
interface plic_ctx_arb_if
    import plic_ctx_arb_pkg::*;
#(
    parameter int NUM_CTX   = PLIC_CTX_NUM,
    parameter int IRQ_WIDTH = PLIC_IRQ_WIDTH
) ();

    logic [NUM_CTX-1:0]           ctx_clam_req_i;
    logic [NUM_CTX-1:0]           ctx_comp_req_i;
    logic [NUM_CTX*IRQ_WIDTH-1:0] ctx_comp_id_i;
    logic [NUM_CTX-1:0]           ctx_ack_o;
    logic [IRQ_WIDTH-1:0]         ctx_rsp_id_o;
    logic                         ctx_rsp_err_o;
    logic                         core_clam_o;
    logic                         core_comp_o;
    logic [IRQ_WIDTH-1:0]         core_id_o;
    logic [IRQ_WIDTH-1:0]         core_id_i;
    logic [NUM_CTX-1:0]           timeout_o;
    state_e                       dbg_state;

    modport master (
        output ctx_clam_req_i, ctx_comp_req_i, ctx_comp_id_i, core_id_i,
        input  ctx_ack_o, ctx_rsp_id_o, ctx_rsp_err_o, core_clam_o, core_comp_o,
        input  core_id_o, timeout_o, dbg_state
    );

    modport slave (
        input  ctx_clam_req_i, ctx_comp_req_i, ctx_comp_id_i, core_id_i,
        output ctx_ack_o, ctx_rsp_id_o, ctx_rsp_err_o, core_clam_o, core_comp_o,
        output core_id_o, timeout_o, dbg_state
    );

endinterface

// File: rtl/plic_ctx_arb_rr.sv
// Round-robin arbiter: searches req starting at ptr, wrapping at N.
//   req     : request vector
//   ptr     : search start index
//   gnt     : one-hot grant
//   gnt_idx : grant index
//   gnt_vld : any request present
module plic_ctx_arb_rr
    import plic_ctx_arb_pkg::*;
#(
    parameter int N  = PLIC_CTX_NUM,
    parameter int CW = ctx_w(PLIC_CTX_NUM)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [CW-1:0] gnt_idx,
    output logic          gnt_vld
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_vld && req[(int'(ptr) + i) % N]) begin
                gnt_vld                   = 1'b1;
                gnt_idx                   = CW'((int'(ptr) + i) % N);
                gnt[(int'(ptr) + i) % N]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plic_ctx_arb.sv
// Shares plic_core's single claim/complete port between NUM_CTX hart contexts.
// One transaction per 3 cycles: IDLE (pick winner) -> ISSUE (core strobe) -> RESP (ack).
// An ownership table records which context claimed each ID; completes from any
// other context, or of ID 0 / unowned IDs, are answered with err and no core strobe.
// Ports: clk_i, rst_n_i (async, active low), bus (plic_ctx_arb_if.slave).
// Optional feature: define PLIC_CTX_ARB_TIMEOUT_EN to force-complete IDs a context
// has held for TIMEOUT_CYC cycles without being acked; otherwise timeout_o is 0.
module plic_ctx_arb
    import plic_ctx_arb_pkg::*;
#(
    parameter int NUM_CTX     = PLIC_CTX_NUM,
    parameter int IRQ_NUM     = PLIC_IRQ_NUM,
    parameter int IRQ_WIDTH   = PLIC_IRQ_WIDTH,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic          clk_i,
    input logic          rst_n_i,
    plic_ctx_arb_if.slave bus
);

    localparam int CW = ctx_w(NUM_CTX);

    if (NUM_CTX < 2 || NUM_CTX > 8 || IRQ_NUM > (1 << IRQ_WIDTH) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("plic_ctx_arb: unsupported parameter set");
    end

    state_e               state;
    op_e                  lat_op;
    logic [CW-1:0]        lat_ctx;
    logic [IRQ_WIDTH-1:0] lat_id;
    logic                 lat_err;
    logic [CW-1:0]        ptr;

    logic [IRQ_NUM-1:0]   own_vld;
    logic [CW-1:0]        own_ctx [IRQ_NUM];

    logic                 clam_q, comp_q, rsp_err_q;
    logic [IRQ_WIDTH-1:0] core_id_q, rsp_id_q;
    logic [NUM_CTX-1:0]   ack_q, tmo_q;

    logic [NUM_CTX-1:0]   gnt;
    logic [CW-1:0]        gnt_idx;
    logic                 gnt_vld;
    logic                 win_comp, win_ok;
    logic [IRQ_WIDTH-1:0] win_id;

    logic                 tmo_vld;
    logic [CW-1:0]        tmo_ctx;
    logic [IRQ_WIDTH-1:0] tmo_id;

    plic_ctx_arb_rr #(.N(NUM_CTX), .CW(CW)) u_rr (
        .req     (bus.ctx_clam_req_i | bus.ctx_comp_req_i),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Complete takes precedence over claim for the same context.
    always_comb begin
        win_comp = |(gnt & bus.ctx_comp_req_i);
        win_id   = bus.ctx_comp_id_i[gnt_idx*IRQ_WIDTH +: IRQ_WIDTH];
        win_ok   = (win_id != '0) && (int'(win_id) < IRQ_NUM) &&
                   own_vld[win_id] && (own_ctx[win_id] == gnt_idx);
    end

`ifdef PLIC_CTX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0]      tmo_cnt [NUM_CTX];
    logic [NUM_CTX-1:0] owns, tmo_pend;

    // Lowest pending context wins; its lowest owned ID is the forced complete.
    always_comb begin
        owns    = '0;
        tmo_vld = 1'b0;
        tmo_ctx = '0;
        tmo_id  = '0;
        for (int i = 1; i < IRQ_NUM; i++)
            if (own_vld[i]) owns[own_ctx[i]] = 1'b1;
        for (int c = 0; c < NUM_CTX; c++)
            tmo_pend[c] = (tmo_cnt[c] == TW'(TIMEOUT_CYC));
        for (int c = NUM_CTX - 1; c >= 0; c--)
            if (tmo_pend[c]) begin
                tmo_vld = 1'b1;
                tmo_ctx = CW'(c);
            end
        for (int i = IRQ_NUM - 1; i >= 1; i--)
            if (own_vld[i] && own_ctx[i] == tmo_ctx) tmo_id = IRQ_WIDTH'(i);
    end

    // Counter saturates at TIMEOUT_CYC until the forced complete reaches RESP.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < NUM_CTX; c++) tmo_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CTX; c++) begin
                if (!owns[c] || (state == ST_RESP && int'(lat_ctx) == c))
                    tmo_cnt[c] <= '0;
                else if (!tmo_pend[c])
                    tmo_cnt[c] <= tmo_cnt[c] + 1'b1;
            end
        end
    end
`else
    assign tmo_vld = 1'b0;
    assign tmo_ctx = '0;
    assign tmo_id  = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            lat_op    <= OP_CLAM;
            lat_ctx   <= '0;
            lat_id    <= '0;
            lat_err   <= 1'b0;
            ptr       <= '0;
            own_vld   <= '0;
            for (int i = 0; i < IRQ_NUM; i++) own_ctx[i] <= '0;
            clam_q    <= 1'b0;
            comp_q    <= 1'b0;
            core_id_q <= '0;
            ack_q     <= '0;
            rsp_id_q  <= '0;
            rsp_err_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            // Strobes, ack and response are single-cycle pulses.
            clam_q    <= 1'b0;
            comp_q    <= 1'b0;
            core_id_q <= '0;
            ack_q     <= '0;
            rsp_id_q  <= '0;
            rsp_err_q <= 1'b0;
            tmo_q     <= '0;
            case (state)
                ST_IDLE: begin
                    if (tmo_vld) begin
                        state     <= ST_ISSUE;
                        lat_op    <= OP_TMO;
                        lat_ctx   <= tmo_ctx;
                        lat_id    <= tmo_id;
                        lat_err   <= 1'b0;
                        comp_q    <= 1'b1;
                        core_id_q <= tmo_id;
                    end else if (gnt_vld) begin
                        state   <= ST_ISSUE;
                        lat_ctx <= gnt_idx;
                        ptr     <= (gnt_idx == CW'(NUM_CTX - 1)) ? '0 : gnt_idx + 1'b1;
                        if (win_comp) begin
                            lat_op  <= OP_COMP;
                            lat_id  <= win_id;
                            lat_err <= !win_ok;
                            if (win_ok) begin
                                comp_q    <= 1'b1;
                                core_id_q <= win_id;
                            end
                        end else begin
                            lat_op  <= OP_CLAM;
                            lat_id  <= '0;
                            lat_err <= 1'b0;
                            clam_q  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_RESP;
                    // Table updates land at the end of ISSUE so a reset inside the
                    // transaction leaves nothing half-written.
                    case (lat_op)
                        OP_CLAM: begin
                            if (bus.core_id_i != '0 && int'(bus.core_id_i) < IRQ_NUM) begin
                                assert (!own_vld[bus.core_id_i]);
                                own_vld[bus.core_id_i] <= 1'b1;
                                own_ctx[bus.core_id_i] <= lat_ctx;
                            end
                            ack_q[lat_ctx] <= 1'b1;
                            rsp_id_q       <= bus.core_id_i;
                        end
                        OP_COMP: begin
                            if (!lat_err) own_vld[lat_id] <= 1'b0;
                            ack_q[lat_ctx] <= 1'b1;
                            rsp_id_q       <= lat_id;
                            rsp_err_q      <= lat_err;
                        end
                        default: begin
                            own_vld[lat_id] <= 1'b0;
                            tmo_q[lat_ctx]  <= 1'b1;
                        end
                    endcase
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.core_clam_o   = clam_q;
    assign bus.core_comp_o   = comp_q;
    assign bus.core_id_o     = core_id_q;
    assign bus.ctx_ack_o     = ack_q;
    assign bus.ctx_rsp_id_o  = rsp_id_q;
    assign bus.ctx_rsp_err_o = rsp_err_q;
    assign bus.timeout_o     = tmo_q;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_plic_ctx_arb.sv
// Bench for plic_ctx_arb: directed cases then randomized traffic, all checked
// against a transaction-level model (owner array, rr pointer, expected queue).
module tb_plic_ctx_arb;
    import plic_ctx_arb_pkg::*;

    localparam int N    = 4;
    localparam int W    = 5;
    localparam int IRQN = 32;
    localparam int RW   = N + 1 + W;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    plic_ctx_arb_if #(.NUM_CTX(N), .IRQ_WIDTH(W)) bus ();

    plic_ctx_arb #(.NUM_CTX(N), .IRQ_NUM(IRQN), .IRQ_WIDTH(W), .TIMEOUT_CYC(1024)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // model state
    int             owner [IRQN];
    int             ptr;
    logic [N-1:0]   clam_p, comp_p;
    logic [W-1:0]   comp_id [N];
    int             force_cid = -1;
    bit             rand_on = 0;
    logic [RW-1:0]  exp_q [$];
    int             total = 0;
    int             bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic apply_reqs();
        bus.ctx_clam_req_i = clam_p;
        bus.ctx_comp_req_i = comp_p;
        for (int c = 0; c < N; c++) bus.ctx_comp_id_i[c*W +: W] = comp_id[c];
    endtask

    task automatic model_reset();
        for (int i = 0; i < IRQN; i++) owner[i] = -1;
        ptr    = 0;
        clam_p = '0;
        comp_p = '0;
        for (int c = 0; c < N; c++) comp_id[c] = '0;
        exp_q.delete();
        apply_reqs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] pick_claim_id();
        int s;
        if (force_cid >= 0) return W'(force_cid);
        if ($urandom_range(0, 7) == 0) return '0;
        s = $urandom_range(1, IRQN - 1);
        for (int k = 0; k < IRQN - 1; k++) begin
            int id = 1 + (s - 1 + k) % (IRQN - 1);
            if (owner[id] < 0) return W'(id);
        end
        return '0;
    endfunction

    function automatic logic [W-1:0] pick_comp_id(input int c);
        int r = $urandom_range(0, 9);
        int s = $urandom_range(1, IRQN - 1);
        for (int k = 0; k < IRQN - 1; k++) begin
            int id = 1 + (s - 1 + k) % (IRQN - 1);
            if (r < 5 && owner[id] == c) return W'(id);
            if (r >= 5 && r < 7 && owner[id] >= 0 && owner[id] != c) return W'(id);
        end
        if (r == 7) return '0;
        return W'($urandom_range(0, IRQN - 1));
    endfunction

    task automatic new_reqs();
        if (!rand_on) return;
        for (int c = 0; c < N; c++) begin
            if (!clam_p[c] && $urandom_range(0, 2) == 0) clam_p[c] = 1'b1;
            if (!comp_p[c] && $urandom_range(0, 2) == 0) begin
                comp_p[c]  = 1'b1;
                comp_id[c] = pick_comp_id(c);
            end
        end
        apply_reqs();
    endtask

    // One arbitration slot; entered at the negedge of an IDLE cycle, leaves at
    // the negedge of the next IDLE cycle.
    task automatic run_txn();
        int           win;
        bit           is_comp, ok;
        logic [W-1:0] id, cid, rsp;
        chk("idle_quiet", {bus.core_clam_o, bus.core_comp_o, bus.ctx_ack_o, bus.timeout_o}, '0);
        win = -1;
        for (int i = 0; i < N; i++) begin
            int j = (ptr + i) % N;
            if (win < 0 && (clam_p[j] || comp_p[j])) win = j;
        end
        if (win < 0) begin
            @(negedge clk);
            new_reqs();
            return;
        end
        is_comp = comp_p[win];
        id      = comp_id[win];
        ok      = is_comp && id != '0 && owner[id] == win;
        ptr     = (win + 1) % N;

        @(negedge clk);
        chk("state_issue", 32'(bus.dbg_state), 32'(ST_ISSUE));
        chk("core_clam", bus.core_clam_o, !is_comp);
        chk("core_comp", bus.core_comp_o, ok);
        chk("core_id", bus.core_id_o, ok ? id : '0);
        chk("ack_early", bus.ctx_ack_o, '0);
        cid = pick_claim_id();
        bus.core_id_i = cid;
        rsp = is_comp ? id : cid;
        exp_q.push_back({N'(1 << win), is_comp && !ok, rsp});

        @(negedge clk);
        bus.core_id_i = W'($urandom_range(0, IRQN - 1));
        chk("strobe_drop", {bus.core_clam_o, bus.core_comp_o, bus.core_id_o}, '0);
        chk("resp", {bus.ctx_ack_o, bus.ctx_rsp_err_o, bus.ctx_rsp_id_o}, exp_q.pop_front());
        if (!is_comp && cid != '0) owner[cid] = win;
        if (ok) owner[id] = -1;
        if (is_comp) comp_p[win] = 1'b0;
        else         clam_p[win] = 1'b0;
        apply_reqs();
        new_reqs();
        @(negedge clk);
    endtask

    initial begin
        bus.core_id_i = '0;
        model_reset();
        do_reset();
        chk("rst_out", {bus.core_clam_o, bus.core_comp_o, bus.core_id_o, bus.ctx_ack_o,
                        bus.ctx_rsp_id_o, bus.ctx_rsp_err_o, bus.timeout_o}, '0);
        chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

        // ctx0 claims 5, ctx1 tries to complete it, ctx0 completes it
        force_cid = 5; clam_p[0] = 1'b1; apply_reqs(); run_txn(); force_cid = -1;
        comp_p[1] = 1'b1; comp_id[1] = 5; apply_reqs(); run_txn();
        comp_p[0] = 1'b1; comp_id[0] = 5; apply_reqs(); run_txn();
        // claim returning 0, complete of ID 0
        force_cid = 0; clam_p[3] = 1'b1; apply_reqs(); run_txn(); force_cid = -1;
        comp_p[2] = 1'b1; comp_id[2] = '0; apply_reqs(); run_txn();
        // claim and complete together: complete goes first
        force_cid = 11; clam_p[1] = 1'b1; apply_reqs(); run_txn(); force_cid = 12;
        clam_p[1] = 1'b1; comp_p[1] = 1'b1; comp_id[1] = 11; apply_reqs();
        run_txn(); run_txn(); force_cid = -1;

        // two waves of all contexts claiming after reset
        do_reset();
        clam_p = '1; apply_reqs();
        repeat (N) run_txn();
        clam_p = '1; apply_reqs();
        repeat (N) run_txn();

        // reset inside ISSUE
        do_reset();
        clam_p[2] = 1'b1; apply_reqs(); bus.core_id_i = 9;
        @(negedge clk);
        chk("pre_rst_clam", bus.core_clam_o, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_clam_drop", bus.core_clam_o, 1'b0);
        chk("rst_mid_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_ack", bus.ctx_ack_o, '0);
        end
        comp_p[2] = 1'b1; comp_id[2] = 9; apply_reqs(); run_txn();

        // randomized traffic
        do_reset();
        rand_on = 1;
        new_reqs();
        repeat (400) run_txn();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
